// File: rtl/mnist_img_loader.sv
// mnist_img_loader
//   Frames the UART byte stream into one MNIST image and writes it into the
//   image RAM. Frame: SYNC_A, SYNC_B, IMG_PIXELS pixel bytes, then one checksum
//   byte (mod-256 sum of the pixel bytes). After a good checksum the image is
//   offered to the inference core via img_valid/img_ack. While img_valid is
//   high, incoming bytes are dropped so the RAM contents stay stable.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rx_done, rx_data    1-cycle byte strobe and byte from the UART receiver
//   ram_we/addr/wdata   image RAM write port (registered)
//   img_valid, img_ack  image handoff to the inference core
//   busy                frame in progress (SYNC/RECV/CHK)
//   err_chk             pulse: checksum mismatch
//   err_timeout         pulse: inter-byte timeout
//   err_ovr             pulse: byte dropped while img_valid=1
module mnist_img_loader #(
  parameter int          IMG_PIXELS  = 784,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  SYNC_A      = 8'hAA,
  parameter logic [7:0]  SYNC_B      = 8'h55,
  parameter int          TIMEOUT_CYC = 25000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              img_valid,
  input  logic              img_ack,
  output logic              busy,
  output logic              err_chk,
  output logic              err_timeout,
  output logic              err_ovr
);

  localparam int                TCNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_RECV,
    S_CHK,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [7:0]          sum, sum_d;
  logic [TCNT_W-1:0]   tcnt, tcnt_d;
  logic                we_d, valid_d, busy_d, chk_d, tmo_d, ovr_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [7:0]          wdata_d;
  logic                expired;

  // Checksum accumulation wraps modulo 256.
  function automatic logic [7:0] sum_wrap(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    return s;
  endfunction

  // A byte in the same cycle as expiry always wins over the timeout.
  assign expired = !rx_done && (tcnt == TCNT_MAX);

  always_comb begin
    state_d = state;
    addr_d  = addr;
    sum_d   = sum;
    tcnt_d  = rx_done ? '0 : tcnt + 1'b1;
    we_d    = 1'b0;
    waddr_d = ram_addr;
    wdata_d = ram_wdata;
    valid_d = img_valid;
    chk_d   = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (rx_done && rx_data == SYNC_A) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (rx_done) begin
          if (rx_data == SYNC_B) begin
            state_d = S_RECV;
            addr_d  = '0;
            sum_d   = '0;
          end else if (rx_data != SYNC_A) begin
            state_d = S_IDLE;
          end
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (rx_done) begin
          we_d    = 1'b1;
          waddr_d = addr;
          wdata_d = rx_data;
          sum_d   = sum_wrap(sum, rx_data);
          addr_d  = addr + 1'b1;
          if (addr == LAST_ADDR) state_d = S_CHK;
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (rx_data == sum) begin
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            chk_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        // Bytes here are dropped unparsed; the ack still takes effect.
        if (rx_done) ovr_d = 1'b1;
        if (img_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout counter only runs while a frame is in flight.
    if (state_d == S_IDLE || state_d == S_DONE) tcnt_d = '0;
    busy_d = (state_d == S_SYNC) || (state_d == S_RECV) || (state_d == S_CHK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      sum         <= '0;
      tcnt        <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      img_valid   <= 1'b0;
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      sum         <= sum_d;
      tcnt        <= tcnt_d;
      ram_we      <= we_d;
      ram_addr    <= waddr_d;
      ram_wdata   <= wdata_d;
      img_valid   <= valid_d;
      busy        <= busy_d;
      err_chk     <= chk_d;
      err_timeout <= tmo_d;
      err_ovr     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_mnist_img_loader.sv
module tb_mnist_img_loader;

  localparam int IMG_PIXELS = 784;
  localparam int ADDR_W     = 10;
  localparam int TMO        = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              img_valid;
  logic              img_ack;
  logic              busy;
  logic              err_chk;
  logic              err_timeout;
  logic              err_ovr;

  mnist_img_loader #(
    .IMG_PIXELS (IMG_PIXELS),
    .ADDR_W     (ADDR_W),
    .SYNC_A     (8'hAA),
    .SYNC_B     (8'h55),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .img_valid  (img_valid),
    .img_ack    (img_ack),
    .busy       (busy),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .err_ovr    (err_ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  logic [ADDR_W+7:0] sbq[$];
  logic s_we, s_valid, s_busy, s_chk, s_tmo, s_ovr;

  always @(posedge clk) if (ram_we === 1'b1) n_wr <= n_wr + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int i);
    int v;
    v = i * (2 * seed + 1) + seed;
    return v[7:0];
  endfunction

  task automatic snap();
    s_we = ram_we; s_valid = img_valid; s_busy = busy;
    s_chk = err_chk; s_tmo = err_timeout; s_ovr = err_ovr;
  endtask

  // Drives one byte; when wr is set the expected RAM write is queued and
  // then matched against the write the DUT makes on the following cycle.
  task automatic send_byte(input logic [7:0] b, input bit wr, input int addr);
    logic [ADDR_W+7:0] e;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    a = addr[ADDR_W-1:0];
    if (wr) sbq.push_back({a, b});
    @(negedge clk);
    rx_done = 1'b0;
    snap();
    if (wr) begin
      check("ram_we", 32'(ram_we), 32'd1);
      if (ram_we === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        check("ram_addr", 32'(ram_addr), 32'(e[ADDR_W+7:8]));
        check("ram_wdata", 32'(ram_wdata), 32'(e[7:0]));
      end
    end else begin
      check("no_ram_we", 32'(ram_we), 32'd0);
    end
  endtask

  task automatic send_sync();
    send_byte(8'hAA, 1'b0, 0);
    check("busy_sync", 32'(s_busy), 32'd1);
    send_byte(8'h55, 1'b0, 0);
    check("busy_recv", 32'(s_busy), 32'd1);
  endtask

  task automatic send_pixels(input int seed, input int n, output logic [7:0] cs);
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      cs = cs + pix(seed, i);
      send_byte(pix(seed, i), 1'b1, i);
    end
  endtask

  // Pixels plus checksum (optionally corrupted) after a sync already sent.
  task automatic send_body(input int seed, input bit bad);
    logic [7:0] cs;
    int w0;
    w0 = n_wr;
    send_pixels(seed, IMG_PIXELS, cs);
    check("busy_chk", 32'(s_busy), 32'd1);
    check("valid_before_cs", 32'(s_valid), 32'd0);
    send_byte(bad ? cs + 8'd1 : cs, 1'b0, 0);
    check("img_valid", 32'(s_valid), bad ? 32'd0 : 32'd1);
    check("err_chk", 32'(s_chk), bad ? 32'd1 : 32'd0);
    check("busy_after_cs", 32'(s_busy), 32'd0);
    check("write_count", 32'(n_wr - w0), 32'(IMG_PIXELS));
    check("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    img_ack = 1'b1;
    @(negedge clk);
    img_ack = 1'b0;
    check("valid_after_ack", 32'(img_valid), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_valid"}, 32'(img_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_errs"}, 32'({err_chk, err_timeout, err_ovr}), 32'd0);
  endtask

  initial begin
    logic [7:0] cs;
    int c;
    bit seen;

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; img_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Ack while idle must be harmless.
    @(negedge clk); img_ack = 1'b1;
    @(negedge clk); img_ack = 1'b0;
    check("idle_ack_valid", 32'(img_valid), 32'd0);

    // 1: reference frame, pixel i = i % 256
    send_sync();
    send_body(0, 1'b0);
    do_ack();

    // 2: same frame with a corrupted checksum
    send_sync();
    send_body(0, 1'b1);
    @(negedge clk);
    check("err_chk_no_stick", 32'(err_chk), 32'd0);
    check("bad_valid_low", 32'(img_valid), 32'd0);

    // 3: junk byte, repeated SYNC_A, then a frame
    send_byte(8'h12, 1'b0, 0);
    check("junk_ignored", 32'(s_busy), 32'd0);
    send_byte(8'hAA, 1'b0, 0);
    check("aa1_busy", 32'(s_busy), 32'd1);
    send_byte(8'hAA, 1'b0, 0);
    check("aa2_busy", 32'(s_busy), 32'd1);
    send_byte(8'h55, 1'b0, 0);
    send_body(1, 1'b0);
    do_ack();

    // 4: stall after pixel 100 until the timeout fires
    send_sync();
    send_pixels(2, 101, cs);
    c = 0; seen = 1'b0;
    while (!seen && c < TMO + 20) begin
      @(negedge clk);
      c++;
      if (err_timeout === 1'b1) seen = 1'b1;
    end
    check("timeout_seen", 32'(seen), 32'd1);
    check("timeout_cycles", 32'(c), 32'(TMO));
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_excl", 32'({err_chk, err_ovr}), 32'd0);
    @(negedge clk);
    check("timeout_no_stick", 32'(err_timeout), 32'd0);
    send_sync();
    send_body(3, 1'b0);

    // 5: bytes while the image is held are dropped
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hAA, 1'b0, 0);
      check("ovr_pulse", 32'(s_ovr), 32'd1);
      check("ovr_valid_held", 32'(s_valid), 32'd1);
    end
    @(negedge clk);
    check("ovr_no_stick", 32'(err_ovr), 32'd0);
    // ack and byte together: ack wins, byte dropped
    rx_done = 1'b1; rx_data = 8'hAA; img_ack = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; img_ack = 1'b0;
    check("ack_rx_valid", 32'(img_valid), 32'd0);
    check("ack_rx_ovr", 32'(err_ovr), 32'd1);
    check("ack_rx_we", 32'(ram_we), 32'd0);
    check("ack_rx_busy", 32'(busy), 32'd0);
    send_sync();
    send_body(4, 1'b0);
    do_ack();

    // 6: reset mid-frame, then a full frame from address 0
    send_sync();
    send_pixels(5, 401, cs);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    send_sync();
    send_body(6, 1'b0);
    do_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
